// File: rtl/wr_1000basex_pcs_tx.sv
// -----------------------------------------------------------------------------
// wr_1000basex_pcs_tx
//   1000BASE-X PCS transmit stage driving a 16-bit (two code-groups per cycle)
//   8b10b PHY TX interface. Lane0 = phy_tx_data_o[7:0] / phy_tx_k_o[0] is the
//   first code-group on the wire.
//
//   Converts a 16-bit frame stream into /S/ + preamble, data, /T/R/ (or
//   D,/T/ + /R/R/ for odd-length frames), IDLE (/I1/ or /I2/ chosen from the
//   PHY running disparity) or /C1/C2/ configuration ordered sets.
//
// Ports
//   clk_ref_i          62.5 MHz reference clock, all logic
//   rst_i              asynchronous reset, active-high
//   src_*              frame source (data, valid, sof, eof, odd, error, ready)
//   an_tx_en_i         send /C1/C2/ ordered sets carrying an_config_i
//   an_config_i        autonegotiation config register
//   phy_rdy_i          PHY ready
//   phy_tx_disparity_i PHY running disparity after last word (1 = positive)
//   phy_tx_data_o/k_o  registered code-groups and K flags to the PHY
//   frame_sent_o       pulse with the /T/ of a good frame
//   frame_abort_o      pulse with the /T/ of an aborted frame
// -----------------------------------------------------------------------------
module wr_1000basex_pcs_tx #(
  parameter int g_min_ifg = 6
) (
  input  logic        clk_ref_i,
  input  logic        rst_i,
  input  logic [15:0] src_data_i,
  input  logic        src_valid_i,
  input  logic        src_sof_i,
  input  logic        src_eof_i,
  input  logic        src_odd_i,
  input  logic        src_error_i,
  output logic        src_ready_o,
  input  logic        an_tx_en_i,
  input  logic [15:0] an_config_i,
  input  logic        phy_rdy_i,
  input  logic        phy_tx_disparity_i,
  output logic [15:0] phy_tx_data_o,
  output logic [1:0]  phy_tx_k_o,
  output logic        frame_sent_o,
  output logic        frame_abort_o
);

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K30_7 = 8'hFE;
  localparam logic [7:0] D5_6  = 8'hC5;
  localparam logic [7:0] D16_2 = 8'h50;
  localparam logic [7:0] D21_5 = 8'hB5;
  localparam logic [7:0] D2_2  = 8'h42;
  localparam logic [7:0] PRE   = 8'h55;
  localparam logic [7:0] SFD   = 8'hD5;

  localparam int IFG_W = (g_min_ifg < 1) ? 1 : $clog2(g_min_ifg + 1);
  localparam logic [IFG_W-1:0] IFG_MAX = IFG_W'(g_min_ifg);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_PREAMBLE, S_DATA, S_EPD, S_DISCARD
  } state_t;

  // End-of-packet sub-sequences: normal /T/R/, trailing /R/R/ after an odd
  // D,/T/ word, and the two-word /V/V/ + /T/R/ abort sequence.
  typedef enum logic [1:0] {
    E_TR, E_RR, E_ABT_V, E_ABT_T
  } epd_t;

  state_t           state;
  epd_t             epd_step;
  logic [1:0]       pre_cnt;
  logic [1:0]       cfg_step;
  logic [IFG_W-1:0] ifg_cnt;
  logic             eof_seen;
  logic             first_idle;
  logic             accept;
  logic             eof_in;
  logic             cfg_latch;

  logic [15:0]      word_p0;
  logic             err_p0;
  logic             eof_p0;
  logic             odd_p0;
  logic [15:0]      cfg_reg;

  // /I1/ flips a positive running disparity back to negative; /I2/ keeps it.
  function automatic logic [15:0] idle_word(input logic use_i1);
    return use_i1 ? {D5_6, K28_5} : {D16_2, K28_5};
  endfunction

  function automatic logic [IFG_W-1:0] ifg_sat_inc(input logic [IFG_W-1:0] v);
    return (v == IFG_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    src_ready_o = 1'b0;
    if (!rst_i) begin
      case (state)
        S_IDLE:     src_ready_o = src_valid_i & ~src_sof_i;  // drop stray words
        S_PREAMBLE: src_ready_o = (pre_cnt == 2'd3);
        S_DATA:     src_ready_o = ~eof_p0;
        S_EPD:      src_ready_o = (epd_step == E_ABT_V) || (epd_step == E_ABT_T);
        S_DISCARD:  src_ready_o = 1'b1;
        default:    src_ready_o = 1'b0;
      endcase
    end
  end

  assign accept    = src_valid_i & src_ready_o;
  assign eof_in    = accept & src_eof_i;
  assign cfg_latch = ((state == S_IDLE) && an_tx_en_i) ||
                     ((state == S_CFG) && !cfg_step[0]);

  // Stage p0: accepted source word, held one cycle before hitting the PHY.
  always_ff @(posedge clk_ref_i) begin
    if (accept && (state == S_PREAMBLE || state == S_DATA)) begin
      word_p0 <= src_data_i;
      err_p0  <= src_error_i;
      eof_p0  <= src_eof_i;
      odd_p0  <= src_odd_i;
    end
    if (cfg_latch) cfg_reg <= an_config_i;
  end

  // Output stage: FSM selects the word registered onto the PHY bus.
  always_ff @(posedge clk_ref_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= S_IDLE;
      epd_step      <= E_TR;
      pre_cnt       <= 2'd0;
      cfg_step      <= 2'd0;
      ifg_cnt       <= IFG_MAX;
      eof_seen      <= 1'b0;
      first_idle    <= 1'b0;
      phy_tx_data_o <= {D16_2, K28_5};
      phy_tx_k_o    <= 2'b01;
      frame_sent_o  <= 1'b0;
      frame_abort_o <= 1'b0;
    end else begin
      frame_sent_o  <= 1'b0;
      frame_abort_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (an_tx_en_i) begin
            phy_tx_data_o <= {D21_5, K28_5};
            phy_tx_k_o    <= 2'b01;
            cfg_step      <= 2'd1;
            state         <= S_CFG;
          end else if (src_valid_i && src_sof_i && phy_rdy_i && ifg_cnt == IFG_MAX) begin
            // /S/ goes out on the same edge so the gap is exactly g_min_ifg.
            phy_tx_data_o <= {PRE, K27_7};
            phy_tx_k_o    <= 2'b01;
            pre_cnt       <= 2'd1;
            state         <= S_PREAMBLE;
          end else begin
            phy_tx_data_o <= idle_word(first_idle & phy_tx_disparity_i & phy_rdy_i);
            phy_tx_k_o    <= 2'b01;
            first_idle    <= 1'b0;
            ifg_cnt       <= ifg_sat_inc(ifg_cnt);
          end
        end

        S_CFG: begin
          cfg_step <= cfg_step + 2'd1;
          case (cfg_step)
            2'd0: begin
              phy_tx_data_o <= {D21_5, K28_5};
              phy_tx_k_o    <= 2'b01;
            end
            2'd2: begin
              phy_tx_data_o <= {D2_2, K28_5};
              phy_tx_k_o    <= 2'b01;
            end
            default: begin
              phy_tx_data_o <= cfg_reg;
              phy_tx_k_o    <= 2'b00;
              // Leave only at the end of a complete /C1/ or /C2/.
              if (!an_tx_en_i) begin
                state      <= S_IDLE;
                ifg_cnt    <= '0;
                first_idle <= 1'b1;
              end
            end
          endcase
        end

        S_PREAMBLE: begin
          if (!phy_rdy_i) begin
            phy_tx_data_o <= {K30_7, K30_7};
            phy_tx_k_o    <= 2'b11;
            eof_seen      <= eof_in;
            epd_step      <= E_ABT_T;
            state         <= S_EPD;
          end else if (pre_cnt == 2'd3) begin
            phy_tx_data_o <= {SFD, PRE};
            phy_tx_k_o    <= 2'b00;
            if (src_valid_i) begin
              state <= S_DATA;
            end else begin
              eof_seen <= 1'b0;
              epd_step <= E_ABT_V;
              state    <= S_EPD;
            end
          end else begin
            phy_tx_data_o <= {PRE, PRE};
            phy_tx_k_o    <= 2'b00;
            pre_cnt       <= pre_cnt + 2'd1;
          end
        end

        S_DATA: begin
          if (!phy_rdy_i) begin
            phy_tx_data_o <= {K30_7, K30_7};
            phy_tx_k_o    <= 2'b11;
            eof_seen      <= eof_p0 | eof_in;
            epd_step      <= E_ABT_T;
            state         <= S_EPD;
          end else begin
            if (err_p0) begin
              phy_tx_data_o <= {K30_7, K30_7};
              phy_tx_k_o    <= 2'b11;
            end else if (eof_p0 && odd_p0) begin
              phy_tx_data_o <= {K29_7, word_p0[7:0]};
              phy_tx_k_o    <= 2'b10;
            end else begin
              phy_tx_data_o <= word_p0;
              phy_tx_k_o    <= 2'b00;
            end
            if (eof_p0) begin
              state <= S_EPD;
              // A corrupted odd tail byte is replaced by /V/V/, so the frame
              // then ends with a plain /T/R/.
              if (odd_p0 && !err_p0) begin
                epd_step     <= E_RR;
                frame_sent_o <= 1'b1;
              end else begin
                epd_step <= E_TR;
              end
            end else if (!src_valid_i) begin
              eof_seen <= 1'b0;
              epd_step <= E_ABT_V;
              state    <= S_EPD;
            end
          end
        end

        S_EPD: begin
          case (epd_step)
            E_TR: begin
              phy_tx_data_o <= {K23_7, K29_7};
              phy_tx_k_o    <= 2'b11;
              frame_sent_o  <= 1'b1;
              ifg_cnt       <= '0;
              first_idle    <= 1'b1;
              state         <= S_IDLE;
            end
            E_RR: begin
              phy_tx_data_o <= {K23_7, K23_7};
              phy_tx_k_o    <= 2'b11;
              ifg_cnt       <= '0;
              first_idle    <= 1'b1;
              state         <= S_IDLE;
            end
            E_ABT_V: begin
              phy_tx_data_o <= {K30_7, K30_7};
              phy_tx_k_o    <= 2'b11;
              eof_seen      <= eof_seen | eof_in;
              epd_step      <= E_ABT_T;
            end
            default: begin
              phy_tx_data_o <= {K23_7, K29_7};
              phy_tx_k_o    <= 2'b11;
              frame_abort_o <= 1'b1;
              first_idle    <= 1'b1;
              if (eof_seen || eof_in) begin
                ifg_cnt <= '0;
                state   <= S_IDLE;
              end else begin
                state <= S_DISCARD;
              end
            end
          endcase
        end

        S_DISCARD: begin
          phy_tx_data_o <= idle_word(first_idle & phy_tx_disparity_i & phy_rdy_i);
          phy_tx_k_o    <= 2'b01;
          first_idle    <= 1'b0;
          if (eof_in) begin
            ifg_cnt <= '0;
            state   <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wr_1000basex_pcs_tx.sv
// -----------------------------------------------------------------------------
// tb_wr_1000basex_pcs_tx
//   Directed bench for wr_1000basex_pcs_tx: a queue-driven frame source,
//   a per-cycle log of the PHY bus, and hand-computed expected words.
// -----------------------------------------------------------------------------
module tb_wr_1000basex_pcs_tx;

  localparam int LOGN = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] src_data;
  logic        src_valid, src_sof, src_eof, src_odd, src_error, src_ready;
  logic        an_tx_en;
  logic [15:0] an_config;
  logic        phy_rdy, phy_disp;
  logic [15:0] phy_data;
  logic [1:0]  phy_k;
  logic        frame_sent, frame_abort;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct packed {
    logic [15:0] d;
    logic        v, sof, eof, odd, err;
  } sw_t;

  sw_t         srcq[$];
  logic [15:0] ld[LOGN];
  logic [1:0]  lk[LOGN];
  logic        ls[LOGN];
  logic        la[LOGN];
  logic        lr[LOGN];
  int          nlog;

  wr_1000basex_pcs_tx #(.g_min_ifg(6)) dut (
    .clk_ref_i          (clk),
    .rst_i              (rst),
    .src_data_i         (src_data),
    .src_valid_i        (src_valid),
    .src_sof_i          (src_sof),
    .src_eof_i          (src_eof),
    .src_odd_i          (src_odd),
    .src_error_i        (src_error),
    .src_ready_o        (src_ready),
    .an_tx_en_i         (an_tx_en),
    .an_config_i        (an_config),
    .phy_rdy_i          (phy_rdy),
    .phy_tx_disparity_i (phy_disp),
    .phy_tx_data_o      (phy_data),
    .phy_tx_k_o         (phy_k),
    .frame_sent_o       (frame_sent),
    .frame_abort_o      (frame_abort)
  );

  always #8 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic sw_t w(input logic [15:0] d, input logic sof, input logic eof,
                            input logic odd, input logic err);
    sw_t s;
    s.d = d; s.v = 1'b1; s.sof = sof; s.eof = eof; s.odd = odd; s.err = err;
    return s;
  endfunction

  // Called 1 time unit after a rising edge; presents the queue head, steps
  // one edge and logs what the DUT registered on it.
  task automatic tick();
    sw_t  h;
    logic acc;
    if (srcq.size() > 0) h = srcq[0];
    else h = '0;
    src_data  = h.d;
    src_valid = h.v;
    src_sof   = h.sof;
    src_eof   = h.eof;
    src_odd   = h.odd;
    src_error = h.err;
    #2;
    acc = src_ready;
    @(posedge clk);
    #1;
    if (srcq.size() > 0 && (!h.v || acc)) srcq.delete(0);
    if (nlog < LOGN) begin
      ld[nlog] = phy_data;
      lk[nlog] = phy_k;
      ls[nlog] = frame_sent;
      la[nlog] = frame_abort;
      lr[nlog] = acc;
      nlog++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pad();
    nlog = 0;
    run(8);
    nlog = 0;
  endtask

  task automatic chk_w(input string tag, input int i, input logic [15:0] d, input logic [1:0] k);
    chk(tag, {14'd0, lk[i], ld[i]}, {14'd0, k, d});
  endtask

  int cnt;

  initial begin
    rst = 1'b1;
    src_data = '0; src_valid = 0; src_sof = 0; src_eof = 0; src_odd = 0; src_error = 0;
    an_tx_en = 0; an_config = '0; phy_rdy = 0; phy_disp = 0;
    nlog = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_data", {16'd0, phy_data}, 32'h50BC);
    chk("rst_k", {30'd0, phy_k}, 32'h1);
    chk("rst_ready", {31'd0, src_ready}, 32'h0);
    chk("rst_pulses", {30'd0, frame_sent, frame_abort}, 32'h0);
    rst = 1'b0;

    // phy not ready: stray non-sof word dropped, frame held, /I2/ only
    srcq.push_back(w(16'hDEAD, 0, 0, 0, 0));
    srcq.push_back(w(16'h1111, 1, 0, 0, 0));
    srcq.push_back(w(16'h2222, 0, 0, 0, 0));
    srcq.push_back(w(16'h3333, 0, 0, 0, 0));
    srcq.push_back(w(16'h4444, 0, 1, 0, 0));
    nlog = 0;
    run(10);
    chk("stray_drop_ready", {31'd0, lr[0]}, 32'h1);
    chk("sof_hold_ready", {31'd0, lr[5]}, 32'h0);
    chk_w("nor 2dy_idle", 9, 16'h50BC, 2'b01);

    // even 4-word frame
    phy_rdy = 1;
    nlog = 0;
    run(20);
    chk_w("even_sop", 0, 16'h55FB, 2'b01);
    chk_w("even_pre1", 1, 16'h5555, 2'b00);
    chk_w("even_pre2", 2, 16'h5555, 2'b00);
    chk_w("even_sfd", 3, 16'hD555, 2'b00);
    chk_w("even_d0", 4, 16'h1111, 2'b00);
    chk_w("even_d1", 5, 16'h2222, 2'b00);
    chk_w("even_d2", 6, 16'h3333, 2'b00);
    chk_w("even_d3", 7, 16'h4444, 2'b00);
    chk_w("even_tr", 8, 16'hF7FD, 2'b11);
    chk("even_sent_at_t", {31'd0, ls[8]}, 32'h1);
    cnt = 0;
    for (int i = 0; i < 20; i++) cnt += int'(ls[i]);
    chk("even_sent_count", cnt, 1);
    chk_w("even_idle_after", 9, 16'h50BC, 2'b01);

    // odd 3-word frame, positive disparity at end -> /I1/ first
    pad();
    phy_disp = 1;
    srcq.push_back(w(16'h0102, 1, 0, 0, 0));
    srcq.push_back(w(16'h0304, 0, 0, 0, 0));
    srcq.push_back(w(16'h00AA, 0, 1, 1, 0));
    run(16);
    chk_w("odd_d0", 4, 16'h0102, 2'b00);
    chk_w("odd_d1", 5, 16'h0304, 2'b00);
    chk_w("odd_dt", 6, 16'hFDAA, 2'b10);
    chk("odd_sent", {31'd0, ls[6]}, 32'h1);
    chk_w("odd_rr", 7, 16'hF7F7, 2'b11);
    chk_w("odd_i1", 8, 16'hC5BC, 2'b01);
    chk_w("odd_i2", 9, 16'h50BC, 2'b01);
    phy_disp = 0;

    // back-to-back frames: exactly 6 idles between /T/R/ and /S/
    pad();
    srcq.push_back(w(16'hA1A1, 1, 0, 0, 0));
    srcq.push_back(w(16'hA2A2, 0, 1, 0, 0));
    srcq.push_back(w(16'hB1B1, 1, 0, 0, 0));
    srcq.push_back(w(16'hB2B2, 0, 1, 0, 0));
    run(22);
    chk_w("b2b_tr1", 6, 16'hF7FD, 2'b11);
    cnt = 0;
    for (int i = 7; i < 20; i++) begin
      if (ld[i] == 16'h55FB) break;
      cnt++;
    end
    chk("b2b_ifg", cnt, 6);
    chk_w("b2b_sop2", 13, 16'h55FB, 2'b01);
    chk_w("b2b_b1", 17, 16'hB1B1, 2'b00);
    chk_w("b2b_tr2", 19, 16'hF7FD, 2'b11);

    // configuration ordered sets; a pending frame must wait
    pad();
    an_tx_en = 1;
    an_config = 16'h01A0;
    srcq.push_back(w(16'hC1C1, 1, 0, 0, 0));
    srcq.push_back(w(16'hC2C2, 0, 1, 0, 0));
    run(6);
    an_tx_en = 0;
    run(18);
    chk_w("cfg_c1", 0, 16'hB5BC, 2'b01);
    chk_w("cfg_c1v", 1, 16'h01A0, 2'b00);
    chk_w("cfg_c2", 2, 16'h42BC, 2'b01);
    chk_w("cfg_c2v", 3, 16'h01A0, 2'b00);
    chk_w("cfg_wrap", 4, 16'hB5BC, 2'b01);
    chk("cfg_ready", {31'd0, lr[2]}, 32'h0);
    chk_w("cfg_last_c2", 6, 16'h42BC, 2'b01);
    chk_w("cfg_last_c2v", 7, 16'h01A0, 2'b00);
    chk_w("cfg_idle", 8, 16'h50BC, 2'b01);
    chk_w("cfg_then_sop", 14, 16'h55FB, 2'b01);
    chk_w("cfg_then_tr", 20, 16'hF7FD, 2'b11);

    // underrun after 2nd word: /V/V/, /T/R/, abort, rest discarded
    pad();
    srcq.push_back(w(16'hD1D1, 1, 0, 0, 0));
    srcq.push_back(w(16'hD2D2, 0, 0, 0, 0));
    srcq.push_back('0);
    srcq.push_back(w(16'hD3D3, 0, 0, 0, 0));
    srcq.push_back(w(16'hD4D4, 0, 1, 0, 0));
    srcq.push_back(w(16'hE1E1, 1, 0, 0, 0));
    srcq.push_back(w(16'hE2E2, 0, 1, 0, 0));
    run(22);
    chk_w("ur_d2", 5, 16'hD2D2, 2'b00);
    chk_w("ur_vv", 6, 16'hFEFE, 2'b11);
    chk_w("ur_tr", 7, 16'hF7FD, 2'b11);
    chk("ur_abort", {31'd0, la[7]}, 32'h1);
    cnt = 0;
    for (int i = 0; i < 14; i++) cnt += int'(ls[i]);
    chk("ur_no_sent", cnt, 0);
    chk_w("ur_next_sop", 14, 16'h55FB, 2'b01);
    chk_w("ur_next_e1", 18, 16'hE1E1, 2'b00);
    chk("ur_next_sent", {31'd0, ls[20]}, 32'h1);

    // error words, including eof together with error
    pad();
    srcq.push_back(w(16'h1234, 1, 0, 0, 0));
    srcq.push_back(w(16'h5678, 0, 0, 0, 1));
    srcq.push_back(w(16'h9ABC, 0, 1, 0, 1));
    run(10);
    chk_w("err_d0", 4, 16'h1234, 2'b00);
    chk_w("err_v1", 5, 16'hFEFE, 2'b11);
    chk_w("err_v2", 6, 16'hFEFE, 2'b11);
    chk_w("err_tr", 7, 16'hF7FD, 2'b11);
    chk("err_sent", {31'd0, ls[7]}, 32'h1);

    // reset in the middle of a frame
    pad();
    srcq.push_back(w(16'h7777, 1, 0, 0, 0));
    srcq.push_back(w(16'h8888, 0, 0, 0, 0));
    srcq.push_back(w(16'h9999, 0, 1, 0, 0));
    run(5);
    chk_w("mid_data", 4, 16'h7777, 2'b00);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_async", {14'd0, phy_k, phy_data}, {14'd0, 2'b01, 16'h50BC});
    @(posedge clk);
    #1;
    chk("midrst_edge", {14'd0, phy_k, phy_data}, {14'd0, 2'b01, 16'h50BC});
    srcq.delete();
    src_valid = 0; src_sof = 0; src_eof = 0;
    rst = 1'b0;
    nlog = 0;
    run(8);
    cnt = 0;
    for (int i = 0; i < 8; i++) cnt += int'(ls[i]) + int'(ld[i] != 16'h50BC);
    chk("midrst_idle_only", cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
